// File: rtl/cpuregs_banked.sv
// rtl/cpuregs_banked.sv - banked PDP-11 general-register file with power-on clear sequencer
// Optional same-edge write-through forwarding: define CPUREGS_BYPASS_EN.
module cpuregs_banked #(
    parameter int             W        = 16,
    parameter logic [W-1:0]   INIT_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [5:0]   raddr_a,
    input  logic [5:0]   raddr_b,
    input  logic [5:0]   waddr,
    input  logic [W-1:0] d,
    input  logic [1:0]   we,
    output logic [W-1:0] qa,
    output logic [W-1:0] qb,
    output logic         busy
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t       state, state_next;
    logic [3:0]   cnt, cnt_next;
    logic [W-1:0] mem [16];

    // R6 is banked by mode (illegal mode 10 aliases user SP); R7 ignores the set bit.
    function automatic logic [3:0] map_addr(input logic [5:0] a);
        logic [3:0] idx;
        idx = {a[3], a[2:0]};
        if (a[2:0] == 3'd6) begin
            case (a[5:4])
                2'b00:   idx = 4'd6;
                2'b01:   idx = 4'd14;
                default: idx = 4'd15;
            endcase
        end else if (a[2:0] == 3'd7) begin
            idx = 4'd7;
        end
        return idx;
    endfunction

    logic [3:0] widx, aidx, bidx;
    logic       wr_lo, wr_hi;

    assign widx  = map_addr(waddr);
    assign aidx  = map_addr(raddr_a);
    assign bidx  = map_addr(raddr_b);
    assign busy  = (state == S_CLEAR);
    assign wr_lo = !busy && we[0];
    assign wr_hi = !busy && we[1];

    function automatic logic [W-1:0] read_entry(input logic [3:0] idx);
        logic [W-1:0] v;
        v = mem[idx];
`ifdef CPUREGS_BYPASS_EN
        if (idx == widx) begin
            if (wr_lo) v[7:0]   = d[7:0];
            if (wr_hi) v[W-1:8] = d[W-1:8];
        end
`endif
        return v;
    endfunction

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_next = cnt + 4'd1;
                if (cnt == 4'd15) state_next = S_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy) begin
                mem[cnt] <= INIT_VAL;
            end else begin
                if (wr_lo) mem[widx][7:0]   <= d[7:0];
                if (wr_hi) mem[widx][W-1:8] <= d[W-1:8];
            end
        end
    end

    // Outputs are forced to zero until the clear has finished so stale contents never leak.
    always_ff @(posedge clk) begin
        if (reset || busy) begin
            qa <= '0;
            qb <= '0;
        end else begin
            qa <= read_entry(aidx);
            qb <= read_entry(bidx);
        end
    end

endmodule

// File: tb/tb_cpuregs_banked.sv
// tb/tb_cpuregs_banked.sv - scoreboard bench for cpuregs_banked against a behavioural model
module tb_cpuregs_banked;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  raddr_a = '0, raddr_b = '0, waddr = '0;
    logic [15:0] d = '0;
    logic [1:0]  we = '0;
    logic [15:0] qa, qb;
    logic        busy;

    cpuregs_banked #(.W(16), .INIT_VAL(16'h0000)) dut (
        .clk(clk), .reset(reset), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .waddr(waddr), .d(d), .we(we), .qa(qa), .qb(qb), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bsy;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] model_mem [16];
    int          clear_left = 0;

    function automatic int model_map(input logic [5:0] a);
        int r, set_bit, mode;
        r = int'(a[2:0]);
        set_bit = int'(a[3]);
        mode = int'(a[5:4]);
        if (r < 6) return set_bit * 8 + r;
        if (r == 7) return 7;
        if (mode == 0) return 6;
        if (mode == 1) return 14;
        return 15;
    endfunction

    function automatic logic [15:0] model_read(input logic [5:0] ra, input logic [5:0] wa,
                                               input logic [15:0] wd, input logic [1:0] wwe);
        logic [15:0] v;
        v = model_mem[model_map(ra)];
`ifdef CPUREGS_BYPASS_EN
        if (model_map(ra) == model_map(wa)) begin
            if (wwe[0]) v = {v[15:8], wd[7:0]};
            if (wwe[1]) v = {wd[15:8], v[7:0]};
        end
`endif
        return v;
    endfunction

    task automatic step(input logic rst, input logic [5:0] ra, input logic [5:0] rb,
                        input logic [5:0] wa, input logic [15:0] wd, input logic [1:0] wwe);
        exp_t e;
        int   idx;
        @(negedge clk);
        reset = rst; raddr_a = ra; raddr_b = rb; waddr = wa; d = wd; we = wwe;
        if (rst) begin
            e.a = 0; e.b = 0; e.bsy = 1'b1;
            clear_left = 16;
        end else if (clear_left > 0) begin
            e.a = 0; e.b = 0;
            clear_left = clear_left - 1;
            e.bsy = (clear_left > 0);
            if (clear_left == 0)
                for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        end else begin
            e.a = model_read(ra, wa, wd, wwe);
            e.b = model_read(rb, wa, wd, wwe);
            e.bsy = 1'b0;
            idx = model_map(wa);
            if (wwe[0]) model_mem[idx][7:0]  = wd[7:0];
            if (wwe[1]) model_mem[idx][15:8] = wd[15:8];
        end
        sb.push_back(e);
    endtask

    task automatic wr(input logic [5:0] wa, input logic [15:0] wd, input logic [1:0] wwe);
        step(1'b0, 6'd0, 6'd0, wa, wd, wwe);
    endtask

    task automatic rd(input logic [5:0] ra, input logic [5:0] rb);
        step(1'b0, ra, rb, 6'd0, 16'h0, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'($urandom), 6'($urandom), 6'($urandom), 16'hBEEF, 2'b11);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (qa !== e.a) begin bad++; $display("FAIL qa: got %h want %h at %0t", qa, e.a, $time); end
            total++;
            if (qb !== e.b) begin bad++; $display("FAIL qb: got %h want %h at %0t", qb, e.b, $time); end
            total++;
            if (busy !== e.bsy) begin bad++; $display("FAIL busy: got %b want %b at %0t", busy, e.bsy, $time); end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] wa;
        // initial clear, then preload everything with 5555
        step(1'b1, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0);
        idle(16);
        for (int i = 0; i < 64; i++) wr(6'(i), 16'h5555, 2'b11);
        step(1'b1, 0, 0, 0, 0, 0);
        idle(16);
        for (int i = 0; i < 64; i++) rd(6'(i), 6'(63 - i));
        // stack-pointer banking
        wr(6'b00_0_110, 16'o001000, 2'b11);
        wr(6'b01_0_110, 16'o002000, 2'b11);
        wr(6'b11_1_110, 16'o003000, 2'b11);
        rd(6'b00_0_110, 6'b01_0_110);
        rd(6'b11_1_110, 6'b10_0_110);
        rd(6'b00_1_110, 6'b01_1_110);
        // set select and R7
        wr(6'b00_0_011, 16'h1111, 2'b11);
        wr(6'b00_1_011, 16'h2222, 2'b11);
        wr(6'b10_1_111, 16'h7777, 2'b11);
        rd(6'b00_0_011, 6'b00_1_011);
        rd(6'b01_0_111, 6'b11_1_111);
        // byte lanes
        wr(6'b00_0_100, 16'hABCD, 2'b11);
        wr(6'b00_0_100, 16'h1234, 2'b01);
        rd(6'b00_0_100, 6'b00_0_100);
        wr(6'b00_0_100, 16'h1234, 2'b10);
        rd(6'b00_0_100, 6'b00_0_100);
        wr(6'b00_0_100, 16'hFFFF, 2'b00);
        rd(6'b00_0_100, 6'b00_0_100);
        // read-during-write
        wr(6'b00_0_010, 16'h0F0F, 2'b11);
        step(1'b0, 6'b00_0_010, 6'b00_0_010, 6'b00_0_010, 16'hF0F0, 2'b11);
        rd(6'b00_0_010, 6'b00_0_010);
        step(1'b0, 6'b00_0_010, 6'b00_0_010, 6'b00_0_010, 16'h3CAA, 2'b01);
        rd(6'b00_0_010, 6'b00_0_010);
        // mid-clear reset
        for (int i = 0; i < 64; i++) wr(6'(i), 16'h5A5A, 2'b11);
        step(1'b1, 0, 0, 0, 0, 0);
        idle(8);
        step(1'b1, 0, 0, 0, 0, 0);
        idle(16);
        for (int i = 0; i < 16; i++) rd(6'(i), 6'(i + 48));
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            wa = 6'($urandom);
            step(($urandom % 80) == 0,
                 ($urandom % 3 == 0) ? wa : 6'($urandom),
                 ($urandom % 3 == 0) ? wa : 6'($urandom),
                 wa, 16'($urandom), 2'($urandom));
        end
        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL drain: got %0d pending want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
